rst_cam_table: RTL and testbench
================================

# rst_cam_table

Parametrised reservation-station table with per-entry valid bits, hardware slot allocation and release, N read and N write ports, and a valid-qualified tag CAM. It sits between dispatch (allocates entries), the CDB/wakeup logic (updates entries by port, looks them up by tag) and issue (reads and frees entries). It removes the fixed two-port layout of earlier tables, resolves write collisions deterministically, and tracks occupancy with full/empty flags.

## Interface
- W_ADDR, 5: entry index width; N_ENTRY = 2**W_ADDR.
- W_DATA, 7: entry payload width.
- W_TAG, 6: tag field width, taken from data[W_TAG-1:0]; W_TAG <= W_DATA.
- N_RPORT, 2: number of read ports, 1 or more.
- N_WPORT, 2: number of update write ports, 1 or more.
- INCLUDE_OREG, 1: 1 gives registered read data; 0 gives combinational read data.
- BYPASS, 0: 1 makes read data show same-cycle writes (next state); 0 shows stored state.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- alloc_req  in  1  request one free entry.
- alloc_data  in  W_DATA  payload written into the allocated entry.
- alloc_gnt  out  1  allocation accepted this cycle.
- alloc_addr  out  W_ADDR  index of the allocated entry; 0 when alloc_gnt=0.
- free_en  in  1  release one entry.
- free_addr  in  W_ADDR  index of the entry to release.
- wport_wen  in  N_WPORT  update enable for each port.
- wport_addr  in  N_WPORT*W_ADDR  packed update indices; port p occupies bits [p*W_ADDR +: W_ADDR].
- wport_data  in  N_WPORT*W_DATA  packed update payloads.
- rport_addr  in  N_RPORT*W_ADDR  packed read indices.
- rport_data  out  N_RPORT*W_DATA  packed read data.
- rport_valid  out  N_RPORT  valid bit of each read entry.
- lookup_tag  in  W_TAG  tag to search for.
- lookup_found  out  1  at least one valid entry matches the tag.
- lookup_addr  out  W_ADDR  lowest matching index; 0 when no entry matches.
- count  out  W_ADDR+1  number of valid entries.
- full, empty  out  1  count==N_ENTRY and count==0.

## Operation
- State: mem_r[N_ENTRY], valid_r[N_ENTRY], count_r. No other state except the read output registers.
- Reset, on the first edge with reset=1:
  - all valid_r, mem_r and the output registers clear to 0; count=0, empty=1, full=0.
  - alloc_gnt is forced to 0 while reset is high, and all write, alloc and free inputs are ignored.
- Allocation:
  - alloc_gnt = alloc_req & !full & !reset.
  - alloc_addr is the lowest-index entry with valid_r=0, taken from registered state.
  - On the edge, the entry is loaded with alloc_data and its valid bit is set.
- Free:
  - free_en on a valid entry clears its valid bit. The payload is kept.
  - free_en on an invalid entry is ignored and count does not change.
  - An entry freed this cycle cannot be allocated until the next cycle.
- Update writes:
  - A write lands only if the target entry's valid_r=1; writes to invalid entries are dropped. Update writes therefore never collide with the entry being allocated.
  - When two ports write the same address, the higher-numbered port wins. This is not an error.
  - When a write and a free hit the same entry, the free wins: the entry becomes invalid. The data write still lands.
- count_next = count + alloc_gnt - (free_en & valid_r[free_addr]). Simultaneous alloc and free leave count unchanged.
- Lookup:
  - Combinational on registered state.
  - Compares lookup_tag against data[W_TAG-1:0] of entries with valid_r=1 only.
  - The lowest matching index wins.
- Reads:
  - rport_data and rport_valid come from mem_r/valid_r, or from next state when BYPASS=1.
  - Any index may be read, including an invalid entry; rport_valid reports which.

## Timing
- alloc_gnt and alloc_addr are combinational in the request cycle. The entry becomes visible to lookup, reads and count at the next cycle.
- Update writes and frees take effect at the edge.
- Read latency:
  - INCLUDE_OREG=1: 1 cycle; output registers reset to 0.
  - INCLUDE_OREG=0: 0 cycles.
- Lookup latency is 0 cycles against current state. A tag written this cycle is found the next cycle.
- Asserting reset in the middle of operation discards any allocation or write in that cycle.

## Structure
- Package rst_pkg holds:
  - a clog2-style helper function;
  - a packed-slice helper (port p of a bus, W bits wide);
  - the default parameter localparams shared by the RS blocks.
- One sub-module, rst_prio_enc (N-bit request to lowest-index binary plus found flag). It is instantiated twice: on the free-entry vector (~valid_r) and on the tag-match vector.
- The write-merge logic and the count update stay in the top module.

## Test plan
- Reset, then 32 cycles of alloc_req=1 with alloc_data=i:
  - alloc_addr runs 0..31;
  - after the 32nd cycle full=1 and count=32;
  - a 33rd request gives alloc_gnt=0.
- Free index 5 and allocate in the same cycle while the table holds 32 entries:
  - alloc_gnt=0 that cycle and count drops to 31;
  - the next cycle, alloc_addr=5.
- Port 0 and port 1 both write index 3 (data 0x11 and 0x22) → the next read of 3 returns 0x22.
- Write to invalid index 9 → the read of 9 returns 0 with rport_valid=0, and the lookup of that tag gives lookup_found=0.
- Entries 4 and 7 both hold tag 0x2A → lookup_addr=4. After freeing 4 → lookup_addr=7.
- INCLUDE_OREG=1: read index 2 → data appears one cycle later. Assert reset mid-stream → rport_data=0 and count=0 the next cycle.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared parameters and elaboration helpers for the reservation-station blocks.
package rst_pkg;

    localparam int unsigned RST_W_ADDR       = 5;
    localparam int unsigned RST_W_DATA       = 7;
    localparam int unsigned RST_W_TAG        = 6;
    localparam int unsigned RST_N_RPORT      = 2;
    localparam int unsigned RST_N_WPORT      = 2;
    localparam bit          RST_INCLUDE_OREG = 1'b1;
    localparam bit          RST_BYPASS       = 1'b0;

    // Never returns 0 so that a single-entry vector still gets a 1-bit index.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return (r == 0) ? 1 : r;
    endfunction

    // LSB of port p within a packed bus of w-bit fields.
    function automatic int unsigned slice_lo(input int unsigned p, input int unsigned w);
        return p * w;
    endfunction

endpackage

// File: rtl/rst_prio_enc.sv
// Lowest-index priority encoder: binary index of the first set request bit plus a found flag.
module rst_prio_enc
    import rst_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned W = clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req_i[i] && !found_o) begin
                idx_o   = W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rst_cam_table.sv
// Reservation-station table: hardware slot allocation/free, N update and read ports,
// and a valid-qualified tag CAM returning the lowest matching entry.
module rst_cam_table
    import rst_pkg::*;
#(
    parameter int unsigned W_ADDR       = RST_W_ADDR,
    parameter int unsigned W_DATA       = RST_W_DATA,
    parameter int unsigned W_TAG        = RST_W_TAG,
    parameter int unsigned N_RPORT      = RST_N_RPORT,
    parameter int unsigned N_WPORT      = RST_N_WPORT,
    parameter bit          INCLUDE_OREG = RST_INCLUDE_OREG,
    parameter bit          BYPASS       = RST_BYPASS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alloc_req,
    input  logic [W_DATA-1:0]           alloc_data,
    output logic                        alloc_gnt,
    output logic [W_ADDR-1:0]           alloc_addr,
    input  logic                        free_en,
    input  logic [W_ADDR-1:0]           free_addr,
    input  logic [N_WPORT-1:0]          wport_wen,
    input  logic [N_WPORT*W_ADDR-1:0]   wport_addr,
    input  logic [N_WPORT*W_DATA-1:0]   wport_data,
    input  logic [N_RPORT*W_ADDR-1:0]   rport_addr,
    output logic [N_RPORT*W_DATA-1:0]   rport_data,
    output logic [N_RPORT-1:0]          rport_valid,
    input  logic [W_TAG-1:0]            lookup_tag,
    output logic                        lookup_found,
    output logic [W_ADDR-1:0]           lookup_addr,
    output logic [W_ADDR:0]             count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned N_ENTRY = 1 << W_ADDR;

    logic [W_DATA-1:0]         mem_q [N_ENTRY];
    logic [W_DATA-1:0]         mem_d [N_ENTRY];
    logic [N_ENTRY-1:0]        valid_q, valid_d;
    logic [W_ADDR:0]           count_q, count_d;
    logic [W_ADDR-1:0]         free_idx;
    logic                      free_found;
    logic [N_ENTRY-1:0]        match_vec;
    logic                      freed;
    logic [N_RPORT*W_DATA-1:0] rd_data;
    logic [N_RPORT-1:0]        rd_valid;

    rst_prio_enc #(.N(N_ENTRY), .W(W_ADDR)) u_free_enc (
        .req_i   (~valid_q),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rst_prio_enc #(.N(N_ENTRY), .W(W_ADDR)) u_match_enc (
        .req_i   (match_vec),
        .idx_o   (lookup_addr),
        .found_o (lookup_found)
    );

    assign count      = count_q;
    assign full       = (count_q == (W_ADDR+1)'(N_ENTRY));
    assign empty      = (count_q == '0);
    assign alloc_gnt  = alloc_req && !full && free_found && !reset;
    assign alloc_addr = alloc_gnt ? free_idx : '0;
    assign freed      = free_en && valid_q[free_addr];

    always_comb begin
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            match_vec[i] = valid_q[i] && (mem_q[i][W_TAG-1:0] == lookup_tag);
        end
    end

    // Writes are gated on pre-edge valid, so they never touch the slot being allocated;
    // loop order makes the highest-numbered port win, and the free is applied last.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        count_d = count_q;
        if (reset) begin
            for (int unsigned i = 0; i < N_ENTRY; i++) mem_d[i] = '0;
            valid_d = '0;
            count_d = '0;
        end else begin
            for (int unsigned p = 0; p < N_WPORT; p++) begin
                if (wport_wen[p] && valid_q[wport_addr[slice_lo(p, W_ADDR) +: W_ADDR]]) begin
                    mem_d[wport_addr[slice_lo(p, W_ADDR) +: W_ADDR]] =
                        wport_data[slice_lo(p, W_DATA) +: W_DATA];
                end
            end
            if (alloc_gnt) begin
                mem_d[alloc_addr]   = alloc_data;
                valid_d[alloc_addr] = 1'b1;
            end
            if (freed) valid_d[free_addr] = 1'b0;
            if (alloc_gnt && !freed)      count_d = count_q + 1'b1;
            else if (!alloc_gnt && freed) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_ENTRY; i++) mem_q[i] <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = '0;
        for (int unsigned p = 0; p < N_RPORT; p++) begin
            if (BYPASS) begin
                rd_data[slice_lo(p, W_DATA) +: W_DATA] = mem_d[rport_addr[slice_lo(p, W_ADDR) +: W_ADDR]];
                rd_valid[p] = valid_d[rport_addr[slice_lo(p, W_ADDR) +: W_ADDR]];
            end else begin
                rd_data[slice_lo(p, W_DATA) +: W_DATA] = mem_q[rport_addr[slice_lo(p, W_ADDR) +: W_ADDR]];
                rd_valid[p] = valid_q[rport_addr[slice_lo(p, W_ADDR) +: W_ADDR]];
            end
        end
    end

    if (INCLUDE_OREG) begin : g_oreg
        logic [N_RPORT*W_DATA-1:0] rd_data_q;
        logic [N_RPORT-1:0]        rd_valid_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= '0;
            end else begin
                rd_data_q  <= rd_data;
                rd_valid_q <= rd_valid;
            end
        end

        assign rport_data  = rd_data_q;
        assign rport_valid = rd_valid_q;
    end else begin : g_comb
        assign rport_data  = rd_data;
        assign rport_valid = rd_valid;
    end

endmodule

// File: tb/tb_rst_cam_table.sv
// Bench for rst_cam_table: directed scenarios plus randomized traffic against a behavioural table model.
module tb_rst_cam_table;

    localparam int WA = 5;
    localparam int WD = 7;
    localparam int WT = 6;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int NE = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_req;
    logic [WD-1:0]     alloc_data;
    logic              alloc_gnt;
    logic [WA-1:0]     alloc_addr;
    logic              free_en;
    logic [WA-1:0]     free_addr;
    logic [NW-1:0]     wport_wen;
    logic [NW*WA-1:0]  wport_addr;
    logic [NW*WD-1:0]  wport_data;
    logic [NR*WA-1:0]  rport_addr;
    logic [NR*WD-1:0]  rport_data;
    logic [NR-1:0]     rport_valid;
    logic [WT-1:0]     lookup_tag;
    logic              lookup_found;
    logic [WA-1:0]     lookup_addr;
    logic [WA:0]       count;
    logic              full;
    logic              empty;

    always #5 clk = ~clk;

    rst_cam_table #(
        .W_ADDR(WA), .W_DATA(WD), .W_TAG(WT), .N_RPORT(NR), .N_WPORT(NW),
        .INCLUDE_OREG(1'b1), .BYPASS(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_data(alloc_data), .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr),
        .free_en(free_en), .free_addr(free_addr),
        .wport_wen(wport_wen), .wport_addr(wport_addr), .wport_data(wport_data),
        .rport_addr(rport_addr), .rport_data(rport_data), .rport_valid(rport_valid),
        .lookup_tag(lookup_tag), .lookup_found(lookup_found), .lookup_addr(lookup_addr),
        .count(count), .full(full), .empty(empty)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: table contents as plain arrays, occupancy derived by counting.
    logic [WD-1:0] m_mem   [NE];
    bit            m_valid [NE];
    logic [WD-1:0] m_rd    [NR];
    bit            m_rv    [NR];
    bit            model_ok = 1'b0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NE; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < NE; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int m_lookup(input logic [WT-1:0] t);
        for (int i = 0; i < NE; i++) if (m_valid[i] && m_mem[i][WT-1:0] == t) return i;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        bit pre_v [NE];
        int ff;
        int a;
        if (reset) begin
            for (int i = 0; i < NE; i++) begin
                m_mem[i]   = '0;
                m_valid[i] = 1'b0;
            end
            for (int p = 0; p < NR; p++) begin
                m_rd[p] = '0;
                m_rv[p] = 1'b0;
            end
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int p = 0; p < NR; p++) begin
                a       = int'(rport_addr[p*WA +: WA]);
                m_rd[p] = m_mem[a];
                m_rv[p] = m_valid[a];
            end
            pre_v = m_valid;
            ff    = m_first_free();
            for (int p = 0; p < NW; p++) begin
                a = int'(wport_addr[p*WA +: WA]);
                if (wport_wen[p] && pre_v[a]) m_mem[a] = wport_data[p*WD +: WD];
            end
            if (alloc_req && ff >= 0) begin
                m_mem[ff]   = alloc_data;
                m_valid[ff] = 1'b1;
            end
            if (free_en && pre_v[int'(free_addr)]) m_valid[int'(free_addr)] = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        int n;
        int ff;
        int lk;
        bit eg;
        if (model_ok) begin
            n  = m_count();
            ff = m_first_free();
            lk = m_lookup(lookup_tag);
            eg = alloc_req && !reset && (n < NE);
            chk("alloc_gnt", 32'(alloc_gnt), 32'(eg));
            chk("alloc_addr", 32'(alloc_addr), eg ? ff : 0);
            chk("count", 32'(count), n);
            chk("full", 32'(full), 32'(n == NE));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("lookup_found", 32'(lookup_found), 32'(lk >= 0));
            chk("lookup_addr", 32'(lookup_addr), (lk >= 0) ? lk : 0);
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("rport_data%0d", p), 32'(rport_data[p*WD +: WD]), 32'(m_rd[p]));
                chk($sformatf("rport_valid%0d", p), 32'(rport_valid[p]), 32'(m_rv[p]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        alloc_req  = 1'b1;
        alloc_data = '0;
        free_en    = 1'b0;
        free_addr  = '0;
        wport_wen  = '0;
        wport_addr = '0;
        wport_data = '0;
        rport_addr = '0;
        lookup_tag = '0;
        tick();
        tick();
        #1;
        chk("reset_count", 32'(count), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_gnt", 32'(alloc_gnt), 0);
        chk("reset_rdata", 32'(rport_data), 0);

        // Update to a never-allocated entry must be dropped.
        reset      = 1'b0;
        alloc_req  = 1'b0;
        wport_wen  = 2'b01;
        wport_addr = {5'd0, 5'd9};
        wport_data = {7'h00, 7'h15};
        tick();
        wport_wen  = '0;
        rport_addr = {5'd0, 5'd9};
        lookup_tag = 6'h15;
        #1;
        chk("inv_lookup_found", 32'(lookup_found), 0);
        tick();
        #1;
        chk("inv_read_data", 32'(rport_data[WD-1:0]), 0);
        chk("inv_read_valid", 32'(rport_valid[0]), 0);

        alloc_req = 1'b1;
        for (int i = 0; i < NE; i++) begin
            alloc_data = WD'(i);
            #1;
            chk("fill_addr", 32'(alloc_addr), i);
            chk("fill_gnt", 32'(alloc_gnt), 1);
            tick();
        end
        #1;
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 32);
        chk("fill_33rd_gnt", 32'(alloc_gnt), 0);

        free_en   = 1'b1;
        free_addr = 5'd5;
        #1;
        chk("free_alloc_gnt", 32'(alloc_gnt), 0);
        tick();
        free_en    = 1'b0;
        alloc_data = 7'd5;
        #1;
        chk("free_count", 32'(count), 31);
        chk("realloc_addr", 32'(alloc_addr), 5);
        chk("realloc_gnt", 32'(alloc_gnt), 1);
        tick();
        alloc_req = 1'b0;

        wport_wen  = 2'b11;
        wport_addr = {5'd3, 5'd3};
        wport_data = {7'h22, 7'h11};
        tick();
        wport_wen  = '0;
        rport_addr = {5'd0, 5'd3};
        tick();
        #1;
        chk("collide_read", 32'(rport_data[WD-1:0]), 32'h22);
        chk("collide_valid", 32'(rport_valid[0]), 1);

        wport_wen  = 2'b11;
        wport_addr = {5'd7, 5'd4};
        wport_data = {7'h2A, 7'h2A};
        tick();
        wport_wen  = '0;
        lookup_tag = 6'h2A;
        #1;
        chk("tag_found", 32'(lookup_found), 1);
        chk("tag_addr_low", 32'(lookup_addr), 4);
        free_en   = 1'b1;
        free_addr = 5'd4;
        tick();
        free_en = 1'b0;
        #1;
        chk("tag_found_after_free", 32'(lookup_found), 1);
        chk("tag_addr_after_free", 32'(lookup_addr), 7);

        rport_addr = {5'd0, 5'd2};
        #1;
        chk("oreg_before_edge", 32'(rport_data[WD-1:0]), 32'h22);
        tick();
        #1;
        chk("oreg_after_edge", 32'(rport_data[WD-1:0]), 2);

        reset      = 1'b1;
        alloc_req  = 1'b1;
        wport_wen  = 2'b11;
        wport_addr = {5'd2, 5'd2};
        wport_data = {7'h7F, 7'h7F};
        tick();
        reset     = 1'b0;
        alloc_req = 1'b0;
        wport_wen = '0;
        #1;
        chk("midreset_rdata", 32'(rport_data), 0);
        chk("midreset_count", 32'(count), 0);

        for (int c = 0; c < 3000; c++) begin
            int ph;
            int ap;
            int fp;
            int ri;
            ph = (c / 300) % 3;
            ap = (ph == 0) ? 85 : (ph == 1) ? 20 : 50;
            fp = (ph == 0) ? 20 : (ph == 1) ? 75 : 50;
            reset      = ($urandom_range(0, 299) == 0);
            alloc_req  = ($urandom_range(0, 99) < ap);
            alloc_data = WD'($urandom);
            free_en    = ($urandom_range(0, 99) < fp);
            free_addr  = WA'($urandom);
            wport_wen  = NW'($urandom);
            for (int p = 0; p < NW; p++) begin
                wport_addr[p*WA +: WA] = ($urandom_range(0, 3) == 0) ? wport_addr[0 +: WA] : WA'($urandom);
                wport_data[p*WD +: WD] = WD'($urandom);
            end
            for (int p = 0; p < NR; p++) rport_addr[p*WA +: WA] = WA'($urandom);
            ri = int'($urandom_range(0, NE - 1));
            lookup_tag = ($urandom_range(0, 1) == 1) ? m_mem[ri][WT-1:0] : WT'($urandom);
            tick();
        end

        reset     = 1'b0;
        alloc_req = 1'b0;
        free_en   = 1'b0;
        wport_wen = '0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
